// File: rtl/fp_div_seq_if.sv
// fp_div_seq handshake bundle.
// Operand request and quotient response, each valid/ready.
interface fp_div_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] q;
   logic        dz;
   logic        inv;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, q, dz, inv
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, q, dz, inv
   );
endinterface

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single divider, restoring, RNE.
// Denormals flush to zero on input and output.
module fp_div_seq (
   input logic         clk,
   input logic         rst,
   fp_div_seq_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, DIV, NORM, ROUND, DONE
   } state_t;

   state_t             state;
   logic [4:0]         cnt;
   logic               sign;
   logic signed [9:0]  expR;
   logic [24:0]        rem;
   logic [23:0]        divisor;
   logic [25:0]        quo;
   logic [23:0]        mant;
   logic               guard;
   logic               sticky;
   logic [31:0]        qR;
   logic               dzR;
   logic               invR;
   logic               outValidR;

   logic [7:0]         expA;
   logic [7:0]         expB;
   logic               fracANz;
   logic               fracBNz;
   logic               zeroA;
   logic               zeroB;
   logic               infA;
   logic               infB;
   logic               nanA;
   logic               nanB;
   logic               sgn;
   logic signed [9:0]  expDiff;

   logic               fits;
   logic [24:0]        remSub;
   logic [25:0]        quoN;
   logic signed [9:0]  expN;
   logic               inc;
   logic [24:0]        mantSum;
   logic [23:0]        mantR;
   logic signed [9:0]  expRnd;

   assign expA    = bus.a[30:23];
   assign expB    = bus.b[30:23];
   assign fracANz = |bus.a[22:0];
   assign fracBNz = |bus.b[22:0];
   assign zeroA   = (expA == 8'd0);
   assign zeroB   = (expB == 8'd0);
   assign infA    = (&expA) & ~fracANz;
   assign infB    = (&expB) & ~fracBNz;
   assign nanA    = (&expA) & fracANz;
   assign nanB    = (&expB) & fracBNz;
   assign sgn     = bus.a[31] ^ bus.b[31];
   assign expDiff = $signed({2'b00, expA})
                  - $signed({2'b00, expB})
                  + 10'sd127;

   assign fits   = (rem >= {1'b0, divisor});
   assign remSub = rem - {1'b0, divisor};

   assign quoN = quo[25] ? quo : {quo[24:0], 1'b0};
   assign expN = quo[25] ? expR : expR - 10'sd1;

   assign inc     = guard & (sticky | mant[0]);
   assign mantSum = {1'b0, mant} + {24'd0, inc};
   assign mantR   = mantSum[24] ? mantSum[24:1]
                                : mantSum[23:0];
   assign expRnd  = mantSum[24] ? expR + 10'sd1 : expR;

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = outValidR;
   assign bus.q         = qR;
   assign bus.dz        = dzR;
   assign bus.inv       = invR;

   // Control FSM with datapath and registered result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         outValidR <= 1'b0;
         qR        <= 32'd0;
         dzR       <= 1'b0;
         invR      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sign <= sgn;
                  dzR  <= 1'b0;
                  invR <= 1'b0;
                  if (nanA | nanB | (zeroA & zeroB)
                      | (infA & infB)) begin
                     qR        <= 32'h7FC00000;
                     invR      <= 1'b1;
                     outValidR <= 1'b1;
                     state     <= DONE;
                  end else if (zeroB & ~infA) begin
                     qR        <= {sgn, 8'hFF, 23'd0};
                     dzR       <= 1'b1;
                     outValidR <= 1'b1;
                     state     <= DONE;
                  end else if (zeroA | infB) begin
                     qR        <= {sgn, 31'd0};
                     outValidR <= 1'b1;
                     state     <= DONE;
                  end else if (infA) begin
                     qR        <= {sgn, 8'hFF, 23'd0};
                     outValidR <= 1'b1;
                     state     <= DONE;
                  end else begin
                     rem     <= {2'b01, bus.a[22:0]};
                     divisor <= {1'b1, bus.b[22:0]};
                     expR    <= expDiff;
                     quo     <= 26'd0;
                     cnt     <= 5'd0;
                     state   <= DIV;
                  end
               end
            end
            DIV: begin
               quo <= {quo[24:0], fits};
               rem <= fits ? {remSub[23:0], 1'b0}
                           : {rem[23:0], 1'b0};
               cnt <= cnt + 5'd1;
               if (cnt == 5'd25) state <= NORM;
            end
            NORM: begin
               mant   <= quoN[25:2];
               guard  <= quoN[1];
               sticky <= quoN[0] | (|rem);
               expR   <= expN;
               state  <= ROUND;
            end
            ROUND: begin
               if (expRnd >= 10'sd255)
                  qR <= {sign, 8'hFF, 23'd0};
               else if (expRnd <= 10'sd0)
                  qR <= {sign, 31'd0};
               else
                  qR <= {sign, expRnd[7:0], mantR[22:0]};
               outValidR <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  outValidR <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
